prefetch_queue: RTL and testbench

//   Parametrised instruction prefetch unit with an integrated byte queue. It

---
 rtl/prefetch_queue.sv | 136 +++++++++++++
 tb/tb_prefetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction prefetch unit with integrated byte queue
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cs, new_ip, load_new_ip    code segment, flush target IP, flush strobe
//   rd_en, rd_two              pop request, pop width (1 = two bytes)
//   rd_data, count, empty      head bytes {next, head}, bytes held, empty flag
//   mem_access, mem_address    registered bus request and word address [19:1]
//   mem_ack, mem_data          bus completion and little-endian read data
module prefetch_queue #(
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   cs,
  input  logic [15:0]   new_ip,
  input  logic          load_new_ip,
  input  logic          rd_en,
  input  logic          rd_two,
  output logic [15:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          mem_access,
  input  logic          mem_ack,
  output logic [19:1]   mem_address,
  input  logic [15:0]   mem_data
);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t        state, state_n;
  logic [7:0]    q   [DEPTH];
  logic [7:0]    q_n [DEPTH];
  logic [15:0]   fetch_ip, fetch_ip_n;
  logic          need2, need2_n;
  logic [CW-1:0] count_n;
  logic          mem_access_n;
  logic [19:1]   mem_address_n;
  logic [19:0]   phys;
  logic [7:0]    byte0, byte1;
  int            cnt_i, pop_i, push_i;

  assign phys    = {cs, 4'h0} + {4'h0, fetch_ip};
  assign empty   = (count == '0);
  // Slots at or beyond count hold stale bytes, so mask them to zero.
  assign rd_data = {(count >= CW'(2)) ? q[1] : 8'h00,
                    (count != '0)     ? q[0] : 8'h00};

  always_comb begin
    state_n       = state;
    fetch_ip_n    = fetch_ip;
    need2_n       = need2;
    mem_access_n  = mem_access;
    mem_address_n = mem_address;
    count_n       = count;
    q_n           = q;
    cnt_i         = int'(count);
    pop_i         = 0;
    push_i        = 0;
    // An odd-address fetch only carries the upper byte of the word.
    byte0         = need2 ? mem_data[7:0] : mem_data[15:8];
    byte1         = mem_data[15:8];

    case (state)
      IDLE: begin
        // Space is reserved at issue time, so the later push can never overflow.
        if (!load_new_ip && (DEPTH - cnt_i) >= (phys[0] ? 1 : 2)) begin
          state_n       = FETCH;
          mem_access_n  = 1'b1;
          mem_address_n = phys[19:1];
          need2_n       = ~phys[0];
        end
      end
      FETCH: begin
        if (mem_ack) begin
          mem_access_n = 1'b0;
          state_n      = IDLE;
          if (!load_new_ip) begin
            push_i     = need2 ? 2 : 1;
            fetch_ip_n = fetch_ip + (need2 ? 16'd2 : 16'd1);
          end
        end else if (load_new_ip) begin
          // The bus cycle cannot be withdrawn; wait it out and drop its data.
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          mem_access_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (!load_new_ip && rd_en && cnt_i >= (rd_two ? 2 : 1))
      pop_i = rd_two ? 2 : 1;

    if (load_new_ip) begin
      fetch_ip_n = new_ip;
      count_n    = '0;
    end else begin
      // Shift out popped bytes, then append pushed bytes behind the survivors.
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == i + pop_i) q_n[i] = q[j];
        end
        if (push_i >= 1 && i == cnt_i - pop_i)     q_n[i] = byte0;
        if (push_i == 2 && i == cnt_i - pop_i + 1) q_n[i] = byte1;
      end
      count_n = CW'(cnt_i - pop_i + push_i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_ip    <= '0;
      need2       <= 1'b0;
      mem_access  <= 1'b0;
      mem_address <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= 8'h00;
    end else begin
      state       <= state_n;
      fetch_ip    <= fetch_ip_n;
      need2       <= need2_n;
      mem_access  <= mem_access_n;
      mem_address <= mem_address_n;
      count       <= count_n;
      q           <= q_n;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - self-checking bench for prefetch_queue
module tb_prefetch_queue;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [15:0]   cs, new_ip, mem_data, rd_data;
  logic          load_new_ip, rd_en, rd_two, mem_ack;
  logic [CW-1:0] count;
  logic          empty, mem_access;
  logic [18:0]   mem_address;

  prefetch_queue #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .cs(cs), .new_ip(new_ip), .load_new_ip(load_new_ip),
    .rd_en(rd_en), .rd_two(rd_two), .rd_data(rd_data), .count(count), .empty(empty),
    .mem_access(mem_access), .mem_ack(mem_ack), .mem_address(mem_address), .mem_data(mem_data)
  );

  // Small-depth instance with its own always-ready bus.
  logic [15:0] cs3, new_ip3, data3, rd_data3;
  logic        load3, rd_en3, rd_two3, ack3, empty3, acc3;
  logic [1:0]  count3;
  logic [18:0] addr3;
  int          max3;

  prefetch_queue #(.DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .cs(cs3), .new_ip(new_ip3), .load_new_ip(load3),
    .rd_en(rd_en3), .rd_two(rd_two3), .rd_data(rd_data3), .count(count3), .empty(empty3),
    .mem_access(acc3), .mem_ack(ack3), .mem_address(addr3), .mem_data(data3)
  );

  function automatic logic [15:0] mem_word(input logic [18:0] a);
    if (a == 19'h7FFF8) return 16'h1234;
    return {a[7:0] ^ 8'hC3, a[7:0]};
  endfunction

  initial begin
    cs3 = 16'h0000; new_ip3 = 16'h0011; load3 = 1'b1; rd_en3 = 1'b0; rd_two3 = 1'b0;
    ack3 = 1'b0; data3 = 16'h0000; max3 = 0;
    @(posedge reset);
    @(negedge clk);
    load3 = 1'b0;
  end

  always @(negedge clk) begin
    if (ack3) ack3 = 1'b0;
    else if (acc3) begin
      ack3  = 1'b1;
      data3 = mem_word(addr3);
    end
    if (reset && int'(count3) > max3) max3 = int'(count3);
  end

  int          tests = 0, fails = 0;
  logic [7:0]  sb[$];
  logic [15:0] m_ip;
  bit          m_discard, bus_en;
  int          ack_delay, wait_cnt, n_fetch, n_acks;
  logic [18:0] last_addr, prev_addr;
  logic        prev_acc, prev_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: bus responder, scoreboard update, then compare after the edge.
  task automatic cycle();
    logic [19:0] phys;
    logic [15:0] w;
    logic [7:0]  e0, e1;
    int          pre, n;
    mem_ack = 1'b0;
    if (mem_access && bus_en) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_address);
        wait_cnt = 0;
        n_acks++;
      end else wait_cnt++;
    end
    pre = sb.size();
    n   = rd_two ? 2 : 1;
    if (load_new_ip) begin
      sb.delete();
      m_ip      = new_ip;
      m_discard = mem_access && !mem_ack;
    end else begin
      if (rd_en && pre >= n) repeat (n) void'(sb.pop_front());
      if (mem_ack) begin
        if (m_discard) m_discard = 1'b0;
        else begin
          phys = {cs, 4'h0} + {4'h0, m_ip};
          check("fetch_addr", 32'(mem_address), 32'(phys[19:1]));
          last_addr = mem_address;
          w = mem_word(phys[19:1]);
          if (phys[0]) sb.push_back(w[15:8]);
          else begin
            sb.push_back(w[7:0]);
            sb.push_back(w[15:8]);
          end
          m_ip = m_ip + (phys[0] ? 16'd1 : 16'd2);
          n_fetch++;
        end
      end
    end
    prev_acc  = mem_access;
    prev_ack  = mem_ack;
    prev_addr = mem_address;
    @(posedge clk);
    @(negedge clk);
    load_new_ip = 1'b0; rd_en = 1'b0; rd_two = 1'b0;
    e0 = (sb.size() >= 1) ? sb[0] : 8'h00;
    e1 = (sb.size() >= 2) ? sb[1] : 8'h00;
    check("count", 32'(count), 32'(sb.size()));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("rd_data", 32'(rd_data), 32'({e1, e0}));
    if (prev_acc && !prev_ack) begin
      check("hold_access", 32'(mem_access), 32'd1);
      check("hold_addr", 32'(mem_address), 32'(prev_addr));
    end
  endtask

  typedef struct {
    logic [15:0] cs;
    logic [15:0] ip;
    logic [18:0] a1;
    int          c1;
    logic [7:0]  head;
    logic [18:0] a2;
    int          c2;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int f0, a0;
    tbl[0] = '{16'hFFFF, 16'h0000, 19'h7FFF8, 2, 8'h34, 19'h7FFF9, 4};
    tbl[1] = '{16'h0000, 16'h0101, 19'h00080, 1, 8'h43, 19'h00081, 3};
    tbl[2] = '{16'hF000, 16'hFFFE, 19'h7FFFF, 2, 8'hFF, 19'h78000, 4};
    tbl[3] = '{16'hFFFF, 16'h0010, 19'h00000, 2, 8'h00, 19'h00001, 4};
    tbl[4] = '{16'h1234, 16'h0005, 19'h091A2, 1, 8'h61, 19'h091A3, 3};

    reset = 1'b0; cs = 16'hFFFF; new_ip = 16'h0000; load_new_ip = 1'b0;
    rd_en = 1'b0; rd_two = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000;
    bus_en = 1'b1; ack_delay = 0; wait_cnt = 0; m_ip = 16'h0000; m_discard = 1'b0;
    n_fetch = 0; n_acks = 0; last_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_access", 32'(mem_access), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_count3", 32'(count3), 32'd0);
    reset = 1'b1;

    // First fetch after reset, then fill to DEPTH and refill after a pop.
    for (int k = 0; k < 10 && sb.size() < 2; k++) cycle();
    check("t1_addr", 32'(last_addr), 32'h7FFF8);
    check("t1_head", 32'(rd_data), 32'h1234);
    repeat (20) cycle();
    check("t3_full", 32'(count), 32'd6);
    check("t3_idle", 32'(mem_access), 32'd0);
    f0 = n_fetch;
    rd_en = 1'b1; rd_two = 1'b1;
    cycle();
    repeat (10) cycle();
    check("t3_refetch", 32'(n_fetch - f0), 32'd1);
    check("t3_refull", 32'(count), 32'd6);

    // Address generation, odd starts and 20-bit wrap.
    for (int r = 0; r < 5; r++) begin
      cs = tbl[r].cs; new_ip = tbl[r].ip; load_new_ip = 1'b1;
      cycle();
      f0 = n_fetch;
      for (int k = 0; k < 20 && n_fetch == f0; k++) cycle();
      check("tbl_addr1", 32'(last_addr), 32'(tbl[r].a1));
      check("tbl_count1", 32'(count), 32'(tbl[r].c1));
      check("tbl_head", 32'(rd_data[7:0]), 32'(tbl[r].head));
      f0 = n_fetch;
      for (int k = 0; k < 20 && n_fetch == f0; k++) cycle();
      check("tbl_addr2", 32'(last_addr), 32'(tbl[r].a2));
      check("tbl_count2", 32'(count), 32'(tbl[r].c2));
    end

    // Short two-byte pop ignored, then combined with a two-byte push.
    cs = 16'h0000; new_ip = 16'h0201; load_new_ip = 1'b1;
    cycle();
    for (int k = 0; k < 20 && sb.size() < 1; k++) cycle();
    bus_en = 1'b0;
    repeat (2) cycle();
    check("t5_count1", 32'(count), 32'd1);
    check("t5_pending", 32'(mem_access), 32'd1);
    rd_en = 1'b1; rd_two = 1'b1;
    cycle();
    check("t5_ignored", 32'(count), 32'd1);
    bus_en = 1'b1; wait_cnt = 0; rd_en = 1'b1; rd_two = 1'b1;
    cycle();
    check("t5_count3", 32'(count), 32'd3);
    check("t5_order", 32'(rd_data), 32'h01C3);
    rd_en = 1'b1;
    cycle();
    check("t5_next", 32'(rd_data), 32'hC201);

    // Flush landing mid-fetch with a slow acknowledge.
    bus_en = 1'b0;
    for (int k = 0; k < 20 && !mem_access; k++) cycle();
    check("t4_busy", 32'(mem_access), 32'd1);
    ack_delay = 3; wait_cnt = 0; bus_en = 1'b1;
    cs = 16'h0000; new_ip = 16'h0400; load_new_ip = 1'b1;
    a0 = n_acks;
    cycle();
    for (int k = 0; k < 10 && n_acks == a0; k++) cycle();
    check("t4_acked", 32'(n_acks - a0), 32'd1);
    check("t4_dropped", 32'(count), 32'd0);
    for (int k = 0; k < 10 && !mem_access; k++) cycle();
    check("t4_new_addr", 32'(mem_address), 32'h00200);
    ack_delay = 0;
    f0 = n_fetch;
    for (int k = 0; k < 10 && n_fetch == f0; k++) cycle();
    check("t4_count", 32'(count), 32'd2);
    check("t4_data", 32'(rd_data), 32'hC300);

    // DEPTH=3 instance started at an odd IP fills exactly to 3.
    check("d3_count", 32'(count3), 32'd3);
    check("d3_max", 32'(max3), 32'd3);
    check("d3_idle", 32'(acc3), 32'd0);
    check("d3_data", 32'(rd_data3), 32'h09CB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
